// File: rtl/veri_pkg.sv
// Shared types and constants for the verification commit port.
// The commit record is what the lockstep checker consumes once per golden-model step.
package veri_pkg;
  localparam int PC_W           = 3;
  localparam int RF_AW          = 2;
  localparam int DATA_W         = 8;
  localparam int LIVE_LIMIT_DEF = 10;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [RF_AW-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rec_t;

  function automatic rec_t mk_rec(logic [PC_W-1:0] pc, logic we,
                                  logic [RF_AW-1:0] rd, logic [DATA_W-1:0] data);
    rec_t r;
    r.pc   = pc;
    r.we   = we;
    r.rd   = rd;
    r.data = data;
    return r;
  endfunction
endpackage

// File: rtl/veri_commit_port_if.sv
// Retire-side and checker-side signals of the commit port.
// VERI_COMMIT_SEQ_EN adds the veri_seq record index.
interface veri_commit_port_if;
  import veri_pkg::*;

  logic              ret0_valid;
  logic [PC_W-1:0]   ret0_pc;
  logic              ret0_we;
  logic [RF_AW-1:0]  ret0_rd;
  logic [DATA_W-1:0] ret0_data;
  logic              ret1_valid;
  logic [PC_W-1:0]   ret1_pc;
  logic              ret1_we;
  logic [RF_AW-1:0]  ret1_rd;
  logic [DATA_W-1:0] ret1_data;
  logic              ret_ready;
  logic              veri_ready;
  logic              veri_valid;
  logic              veri_commit;
  logic [PC_W-1:0]   veri_pc;
  logic              veri_we;
  logic [RF_AW-1:0]  veri_rd;
  logic [DATA_W-1:0] veri_data;
  logic [PC_W-1:0]   c_pc_last;
  logic              veri_live;
  logic              err;
`ifdef VERI_COMMIT_SEQ_EN
  logic [15:0]       veri_seq;

  modport master (
    input  ret0_valid, ret0_pc, ret0_we, ret0_rd, ret0_data,
           ret1_valid, ret1_pc, ret1_we, ret1_rd, ret1_data, veri_ready,
    output ret_ready, veri_valid, veri_commit, veri_pc, veri_we, veri_rd,
           veri_data, c_pc_last, veri_live, err, veri_seq
  );
  modport slave (
    output ret0_valid, ret0_pc, ret0_we, ret0_rd, ret0_data,
           ret1_valid, ret1_pc, ret1_we, ret1_rd, ret1_data, veri_ready,
    input  ret_ready, veri_valid, veri_commit, veri_pc, veri_we, veri_rd,
           veri_data, c_pc_last, veri_live, err, veri_seq
  );
`else
  modport master (
    input  ret0_valid, ret0_pc, ret0_we, ret0_rd, ret0_data,
           ret1_valid, ret1_pc, ret1_we, ret1_rd, ret1_data, veri_ready,
    output ret_ready, veri_valid, veri_commit, veri_pc, veri_we, veri_rd,
           veri_data, c_pc_last, veri_live, err
  );
  modport slave (
    output ret0_valid, ret0_pc, ret0_we, ret0_rd, ret0_data,
           ret1_valid, ret1_pc, ret1_we, ret1_rd, ret1_data, veri_ready,
    input  ret_ready, veri_valid, veri_commit, veri_pc, veri_we, veri_rd,
           veri_data, c_pc_last, veri_live, err
  );
`endif
endinterface

// File: rtl/veri_commit_fifo.sv
// Two-write / one-read circular commit queue with occupancy count.
// When empty, the head output keeps presenting the last record that sat at the head.
module veri_commit_fifo
  import veri_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr0_en,
  input  rec_t          wr0,
  input  logic          wr1_en,
  input  rec_t          wr1,
  input  logic          rd_en,
  output rec_t          head,
  output logic [CW-1:0] count
);
  localparam logic [AW-1:0] ONE = AW'(1);

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  rec_t          last_q, last_d;
  logic [1:0]    n_push;
  logic          pop;

  always_comb begin
    mem_d   = mem_q;
    last_d  = last_q;
    n_push  = {1'b0, wr0_en} + {1'b0, wr1_en};
    pop     = rd_en && (count_q != '0);
    if (wr0_en) mem_d[tail_q] = wr0;
    if (wr1_en) mem_d[tail_q + ONE] = wr1;
    tail_d  = tail_q + AW'(n_push);
    head_d  = head_q + AW'(pop);
    count_d = count_q + CW'(n_push) - CW'(pop);
    // Capture the head while valid so it can be replayed once the queue drains.
    if (count_q != '0) last_d = mem_q[head_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign head  = (count_q != '0) ? mem_q[head_q] : last_q;
  assign count = count_q;
endmodule

// File: rtl/veri_commit_port.sv
// Commit-port transmitter: queues in-order retirements, hands one record per cycle to the
// lockstep checker, tracks last committed PC, liveness and sticky errors. Option: VERI_COMMIT_SEQ_EN.
module veri_commit_port
  import veri_pkg::*;
#(
  parameter  int              DEPTH      = 4,
  parameter  logic [PC_W-1:0] RESET_PC   = '0,
  parameter  int              LIVE_LIMIT = LIVE_LIMIT_DEF,
  localparam int              CW         = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                rst,
  veri_commit_port_if.master io
);
  rec_t            rec0, rec1, head;
  logic [CW-1:0]   count;
  logic            ret_ready, acc0, acc1, veri_valid, veri_commit;
  logic [PC_W-1:0] c_pc_last_q, c_pc_last_d;
  logic [3:0]      stall_q, stall_d;
  logic            err_q, err_d;

  always_comb begin
    rec0 = mk_rec(io.ret0_pc, io.ret0_we, io.ret0_rd, io.ret0_data);
    rec1 = mk_rec(io.ret1_pc, io.ret1_we, io.ret1_rd, io.ret1_data);
  end

  // Readiness is judged on pre-pop occupancy; a younger slot never goes in alone.
  assign ret_ready   = count <= CW'(DEPTH - 2);
  assign acc0        = io.ret0_valid & ret_ready;
  assign acc1        = acc0 & io.ret1_valid;
  assign veri_valid  = count != '0;
  assign veri_commit = veri_valid & io.veri_ready;

  veri_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr0_en (acc0),
    .wr0    (rec0),
    .wr1_en (acc1),
    .wr1    (rec1),
    .rd_en  (veri_commit),
    .head   (head),
    .count  (count)
  );

  always_comb begin
    c_pc_last_d = veri_commit ? head.pc : c_pc_last_q;
    err_d       = err_q | (io.ret1_valid & ~io.ret0_valid) | (io.ret0_valid & ~ret_ready);
    if (veri_commit)          stall_d = '0;
    else if (stall_q == 4'hF) stall_d = stall_q;
    else                      stall_d = stall_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_pc_last_q <= RESET_PC;
      stall_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      c_pc_last_q <= c_pc_last_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

`ifdef VERI_COMMIT_SEQ_EN
  logic [15:0] seq_q, seq_d;

  assign seq_d = veri_commit ? seq_q + 16'd1 : seq_q;

  always_ff @(posedge clk) begin
    if (rst) seq_q <= '0;
    else     seq_q <= seq_d;
  end

  assign io.veri_seq = seq_q;
`endif

  assign io.ret_ready   = ret_ready;
  assign io.veri_valid  = veri_valid;
  assign io.veri_commit = veri_commit;
  assign io.veri_pc     = head.pc;
  assign io.veri_we     = head.we;
  assign io.veri_rd     = head.rd;
  assign io.veri_data   = head.data;
  assign io.c_pc_last   = c_pc_last_q;
  assign io.veri_live   = int'({1'b0, stall_q}) < LIVE_LIMIT;
  assign io.err         = err_q;
endmodule

// File: tb/tb_veri_commit_port.sv
// Directed bench for veri_commit_port: reset/watchdog sequence, a vector table for the
// queue/commit/error flow, and a sequence-counter run when VERI_COMMIT_SEQ_EN is defined.
module tb_veri_commit_port;
  import veri_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  veri_commit_port_if io();

  veri_commit_port #(.DEPTH(4), .RESET_PC(3'd0), .LIVE_LIMIT(10)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic rs, r0v, r1v, vr;
    rec_t r0, r1;
    logic e_vv, e_vc, e_rr, e_err;
    rec_t e_head;
    logic [PC_W-1:0] e_cpl;
  } vec_t;

  function automatic vec_t v(logic rs, logic r0v, rec_t r0, logic r1v, rec_t r1, logic vr,
                             logic vv, logic vc, logic rr, logic er, rec_t hd, logic [2:0] cpl);
    vec_t t;
    t.rs = rs; t.r0v = r0v; t.r0 = r0; t.r1v = r1v; t.r1 = r1; t.vr = vr;
    t.e_vv = vv; t.e_vc = vc; t.e_rr = rr; t.e_err = er; t.e_head = hd; t.e_cpl = cpl;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge; outputs are then sampled 1ns later, well away from posedge.
  task automatic apply(logic rs, logic r0v, rec_t r0, logic r1v, rec_t r1, logic vr);
    @(negedge clk);
    rst           = rs;
    io.ret0_valid = r0v;
    io.ret0_pc    = r0.pc;
    io.ret0_we    = r0.we;
    io.ret0_rd    = r0.rd;
    io.ret0_data  = r0.data;
    io.ret1_valid = r1v;
    io.ret1_pc    = r1.pc;
    io.ret1_we    = r1.we;
    io.ret1_rd    = r1.rd;
    io.ret1_data  = r1.data;
    io.veri_ready = vr;
    #1;
  endtask

  function automatic logic [31:0] head_now();
    rec_t h;
    h = mk_rec(io.veri_pc, io.veri_we, io.veri_rd, io.veri_data);
    return 32'(h);
  endfunction

  vec_t tbl [24];
  rec_t Z, R1, R2, R3, R4, R5, R6, R7, RA, RB, RX;

  initial begin
    Z  = '0;
    R1 = mk_rec(3'd1, 1'b0, 2'd3, 8'h11);
    R2 = mk_rec(3'd2, 1'b1, 2'd1, 8'h5A);
    R3 = mk_rec(3'd3, 1'b0, 2'd2, 8'h33);
    R4 = mk_rec(3'd4, 1'b1, 2'd3, 8'h44);
    R5 = mk_rec(3'd5, 1'b1, 2'd0, 8'h55);
    R6 = mk_rec(3'd6, 1'b0, 2'd1, 8'h66);
    R7 = mk_rec(3'd7, 1'b1, 2'd2, 8'h77);
    RA = mk_rec(3'd2, 1'b1, 2'd0, 8'h22);
    RB = mk_rec(3'd3, 1'b0, 2'd1, 8'h23);
    RX = mk_rec(3'd6, 1'b1, 2'd2, 8'h99);

    //            rs r0v r0 r1v r1 vr   vv vc rr er head cpl
    tbl[0]  = v(0, 1, R2, 0, Z,  1,  0, 0, 1, 0, Z,  3'd0);
    tbl[1]  = v(0, 0, Z,  0, Z,  1,  1, 1, 1, 0, R2, 3'd0);
    tbl[2]  = v(0, 0, Z,  0, Z,  1,  0, 0, 1, 0, R2, 3'd2);
    tbl[3]  = v(0, 1, R3, 1, R4, 1,  0, 0, 1, 0, R2, 3'd2);
    tbl[4]  = v(0, 0, Z,  0, Z,  1,  1, 1, 1, 0, R3, 3'd2);
    tbl[5]  = v(0, 0, Z,  0, Z,  1,  1, 1, 1, 0, R4, 3'd3);
    tbl[6]  = v(0, 0, Z,  0, Z,  0,  0, 0, 1, 0, R4, 3'd4);
    tbl[7]  = v(0, 1, R5, 1, R6, 0,  0, 0, 1, 0, R4, 3'd4);
    tbl[8]  = v(0, 1, R7, 1, R1, 0,  1, 0, 1, 0, R5, 3'd4);
    tbl[9]  = v(0, 1, RA, 1, RB, 0,  1, 0, 0, 0, R5, 3'd4);
    tbl[10] = v(0, 0, Z,  1, RX, 0,  1, 0, 0, 1, R5, 3'd4);
    tbl[11] = v(0, 0, Z,  0, Z,  1,  1, 1, 0, 1, R5, 3'd4);
    tbl[12] = v(0, 0, Z,  0, Z,  1,  1, 1, 0, 1, R6, 3'd5);
    tbl[13] = v(0, 0, Z,  0, Z,  1,  1, 1, 1, 1, R7, 3'd6);
    tbl[14] = v(0, 1, RA, 1, RB, 1,  1, 1, 1, 1, R1, 3'd7);
    tbl[15] = v(0, 0, Z,  0, Z,  1,  1, 1, 1, 1, RA, 3'd1);
    tbl[16] = v(0, 0, Z,  0, Z,  1,  1, 1, 1, 1, RB, 3'd2);
    tbl[17] = v(0, 0, Z,  0, Z,  1,  0, 0, 1, 1, RB, 3'd3);
    tbl[18] = v(1, 0, Z,  0, Z,  1,  0, 0, 1, 1, RB, 3'd3);
    tbl[19] = v(0, 0, Z,  1, RX, 1,  0, 0, 1, 0, Z,  3'd0);
    tbl[20] = v(0, 0, Z,  0, Z,  1,  0, 0, 1, 1, Z,  3'd0);
    tbl[21] = v(0, 1, R5, 1, R6, 0,  0, 0, 1, 1, Z,  3'd0);
    tbl[22] = v(1, 0, Z,  0, Z,  0,  1, 0, 1, 1, R5, 3'd0);
    tbl[23] = v(0, 0, Z,  0, Z,  1,  0, 0, 1, 0, Z,  3'd0);

    // Reset, then idle with the checker ready: watchdog drops at cycle 10 and saturates.
    apply(1, 0, Z, 0, Z, 1);
    apply(1, 0, Z, 0, Z, 1);
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, Z, 0, Z, 1);
      if (i == 0) begin
        chk("rst_err", 32'(io.err), 32'd0);
        chk("rst_rr", 32'(io.ret_ready), 32'd1);
        chk("rst_vc", 32'(io.veri_commit), 32'd0);
        chk("rst_head", head_now(), 32'd0);
      end
      chk($sformatf("idle%0d_vv", i), 32'(io.veri_valid), 32'd0);
      chk($sformatf("idle%0d_cpl", i), 32'(io.c_pc_last), 32'd0);
      chk($sformatf("idle%0d_live", i), 32'(io.veri_live), (i < 10) ? 32'd1 : 32'd0);
    end

    apply(1, 0, Z, 0, Z, 1);
    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].rs, tbl[i].r0v, tbl[i].r0, tbl[i].r1v, tbl[i].r1, tbl[i].vr);
      chk($sformatf("row%0d_vv", i), 32'(io.veri_valid), 32'(tbl[i].e_vv));
      chk($sformatf("row%0d_vc", i), 32'(io.veri_commit), 32'(tbl[i].e_vc));
      chk($sformatf("row%0d_rr", i), 32'(io.ret_ready), 32'(tbl[i].e_rr));
      chk($sformatf("row%0d_err", i), 32'(io.err), 32'(tbl[i].e_err));
      chk($sformatf("row%0d_head", i), head_now(), 32'(tbl[i].e_head));
      chk($sformatf("row%0d_cpl", i), 32'(io.c_pc_last), 32'(tbl[i].e_cpl));
    end

    // Three commits back to back, then a reset mid-stream.
    apply(1, 0, Z, 0, Z, 1);
    apply(0, 1, R2, 1, R3, 1);
    chk("seq0_vv", 32'(io.veri_valid), 32'd0);
`ifdef VERI_COMMIT_SEQ_EN
    chk("seq0_seq", 32'(io.veri_seq), 32'd0);
`endif
    apply(0, 1, R4, 0, Z, 1);
    chk("seq1_vc", 32'(io.veri_commit), 32'd1);
    chk("seq1_head", head_now(), 32'(R2));
`ifdef VERI_COMMIT_SEQ_EN
    chk("seq1_seq", 32'(io.veri_seq), 32'd0);
`endif
    apply(0, 0, Z, 0, Z, 1);
    chk("seq2_vc", 32'(io.veri_commit), 32'd1);
    chk("seq2_head", head_now(), 32'(R3));
`ifdef VERI_COMMIT_SEQ_EN
    chk("seq2_seq", 32'(io.veri_seq), 32'd1);
`endif
    apply(0, 0, Z, 0, Z, 1);
    chk("seq3_vc", 32'(io.veri_commit), 32'd1);
    chk("seq3_head", head_now(), 32'(R4));
`ifdef VERI_COMMIT_SEQ_EN
    chk("seq3_seq", 32'(io.veri_seq), 32'd2);
`endif
    apply(0, 0, Z, 0, Z, 0);
    chk("seq4_vv", 32'(io.veri_valid), 32'd0);
    chk("seq4_cpl", 32'(io.c_pc_last), 32'd4);
`ifdef VERI_COMMIT_SEQ_EN
    chk("seq4_seq", 32'(io.veri_seq), 32'd3);
`endif
    apply(1, 0, Z, 0, Z, 0);
    apply(0, 0, Z, 0, Z, 1);
    chk("seq5_cpl", 32'(io.c_pc_last), 32'd0);
`ifdef VERI_COMMIT_SEQ_EN
    chk("seq5_seq", 32'(io.veri_seq), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/veri_commit_port.md
Name: veri_commit_port

Overview:
- Transmitter side of the OOO core's verification commit interface; lives inside the OOO core, next to the ROB retire stage.
- Accepts up to two in-order retirements per cycle and queues them as commit records.
- Presents at most one record per cycle to the lockstep checker, which steps the ISA golden model once per record.
- Drives the architectural "last committed PC" register and a liveness watchdog for the checker.

Parameters:
PC_W, 3, PC width (8-entry instruction memory)
RF_AW, 2, register-file index width (4 registers)
DATA_W, 8, register data width
DEPTH, 4, commit queue entries (power of two, >=2)
RESET_PC, 0, reset value of c_pc_last
LIVE_LIMIT, 10, max cycles without a commit before veri_live drops

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ret0_valid  in  1  older retiring instruction valid
ret0_pc  in  PC_W  its PC
ret0_we  in  1  writes a register
ret0_rd  in  RF_AW  destination index
ret0_data  in  DATA_W  write data
ret1_valid/ret1_pc/ret1_we/ret1_rd/ret1_data  in  as above  younger retiring instruction
ret_ready  out  1  ROB may retire (>=2 free entries)
veri_ready  in  1  checker accepts a record this cycle
veri_valid  out  1  queue head valid
veri_commit  out  1  record transferred this cycle (veri_valid & veri_ready)
veri_pc  out  PC_W  head PC
veri_we  out  1  head write-enable
veri_rd  out  RF_AW  head destination
veri_data  out  DATA_W  head data
c_pc_last  out  PC_W  PC of last transferred record
veri_live  out  1  watchdog OK
err  out  1  sticky protocol/overflow error

Behaviour:
- Reset values: queue empty, veri_valid=0, veri_commit=0, c_pc_last=RESET_PC, stall counter 0, veri_live=1, err=0. rst mid-operation discards all queued records.
- Queue: circular buffer; head/tail pointers are log2(DEPTH) bits and wrap naturally; a separate count runs 0..DEPTH.
- Push: ret0 is written at tail and ret1 at tail+1; tail advances by the number of valid slots. Push is visible at the head the next cycle, so enqueue-to-veri_valid latency is 1 cycle.
- ret_ready is combinational: (DEPTH - count) >= 2. It is computed before the same-cycle pop.
- Pop: when veri_valid && veri_ready, head advances and c_pc_last <= veri_pc on the same edge. veri_commit = veri_valid & veri_ready (combinational pulse).
- Simultaneous push and pop is allowed: count += pushes - pop.
- Empty queue: veri_valid=0 and the veri_* data outputs hold the last head contents; veri_ready is then ignored.
- Full queue: ret_ready=0.
- Error rules (err sets and stays set until rst; record contents unaffected):
  - Push while ret_ready=0: the records are dropped and err is set.
  - ret1_valid without ret0_valid: ret1 is ignored and err is set.
- Watchdog: 4-bit saturating stall_cnt, cleared on veri_commit, otherwise incremented (saturates at 15). veri_live = (stall_cnt < LIVE_LIMIT), registered-free compare.

Optional Feature:
- Macro VERI_COMMIT_SEQ_EN.
- Defined: adds output veri_seq (16 bits), the index of the head record. It starts at 0 after reset, increments on each veri_commit and wraps at 2^16.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package veri_pkg holds:
  - commit record typedef {pc, we, rd, data}.
  - Constants PC_W, RF_AW, DATA_W.
  - LIVE_LIMIT default.
- One natural sub-module: veri_commit_fifo, a 2-write/1-read circular queue with count. The top-level adds c_pc_last, the watchdog, err, and the optional sequence counter.

Test Plan:
- Reset then idle 12 cycles with veri_ready=1 -> veri_valid=0, c_pc_last=0; veri_live=1 through cycle 9 (stall_cnt<10), veri_live=0 from cycle 10 on.
- Single retire ret0 {pc=2, we=1, rd=1, data=0x5A} with veri_ready=1 -> next cycle veri_valid=1 and veri_commit=1 with the same fields; following cycle c_pc_last=2 and the queue is empty.
- Dual retire {pc=3},{pc=4} with veri_ready=1 -> two consecutive veri_commit pulses in order 3 then 4; c_pc_last ends at 4.
- Hold veri_ready=0 and issue dual retires on two cycles (DEPTH=4) -> count=4, ret_ready=0. Release veri_ready -> 4 in-order commits; ret_ready rises when count<=2. Pointers wrap, and a further dual retire is delivered correctly.
- Dual retire while ret_ready=0 -> err=1 sticky, queue unchanged. Also ret1_valid=1 with ret0_valid=0 -> err=1, nothing pushed. rst -> err=0, queue empty.
- With VERI_COMMIT_SEQ_EN: 3 commits -> veri_seq reads 0, 1, 2 on the commit cycles. Reset mid-stream -> veri_seq=0.
